// File: rtl/ls_queue_pkg.sv
// Shared definitions for the load/store queue: op codes, widths, sentinel tags
// and the packed per-entry record.
package ls_queue_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int ROB_W   = 5;
    localparam int OPNUM_W = 4;

    localparam logic [ROB_W-1:0]   INVALID_ROB = '1;
    localparam logic [ADDR_W-1:0]  RAM_IO_ADDR = 32'h0003_0000;
    localparam logic [DATA_W-1:0]  NULL        = '0;

    // Loads occupy the low codes, stores the high ones.
    localparam logic [OPNUM_W-1:0] OPNUM_LB  = 4'd0;
    localparam logic [OPNUM_W-1:0] OPNUM_LH  = 4'd1;
    localparam logic [OPNUM_W-1:0] OPNUM_LW  = 4'd2;
    localparam logic [OPNUM_W-1:0] OPNUM_LBU = 4'd3;
    localparam logic [OPNUM_W-1:0] OPNUM_LHU = 4'd4;
    localparam logic [OPNUM_W-1:0] OPNUM_SB  = 4'd5;
    localparam logic [OPNUM_W-1:0] OPNUM_SH  = 4'd6;
    localparam logic [OPNUM_W-1:0] OPNUM_SW  = 4'd7;

    typedef struct packed {
        logic               busy;
        logic               committed;
        logic [OPNUM_W-1:0] opnum;
        logic [DATA_W-1:0]  v1;
        logic [DATA_W-1:0]  v2;
        logic [DATA_W-1:0]  imm;
        logic [ROB_W-1:0]   q1;
        logic [ROB_W-1:0]   q2;
        logic [ROB_W-1:0]   rob_id;
    } ls_entry_t;

    localparam ls_entry_t ENTRY_RST = '{busy: 1'b0, committed: 1'b0, opnum: '0,
                                        v1: '0, v2: '0, imm: '0,
                                        q1: INVALID_ROB, q2: INVALID_ROB, rob_id: '0};

    function automatic logic is_load(input logic [OPNUM_W-1:0] op);
        return op <= OPNUM_LHU;
    endfunction

    function automatic logic is_store(input logic [OPNUM_W-1:0] op);
        return op >= OPNUM_SB;
    endfunction

endpackage

// File: rtl/ls_operand_capture.sv
// Matches one operand tag against all writeback buses; the lowest-numbered
// matching bus supplies the data.
module ls_operand_capture
    import ls_queue_pkg::*;
#(
    parameter int N_BUS = 2
) (
    input  logic [ROB_W-1:0]        tag_i,
    input  logic [N_BUS-1:0]        wb_valid_i,
    input  logic [N_BUS*ROB_W-1:0]  wb_rob_id_i,
    input  logic [N_BUS*DATA_W-1:0] wb_data_i,
    output logic                    hit_o,
    output logic [DATA_W-1:0]       data_o
);

    // Walk from the highest bus down so the lowest index is written last.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = N_BUS - 1; k >= 0; k--) begin
            if (wb_valid_i[k] && (tag_i != INVALID_ROB) &&
                (wb_rob_id_i[k*ROB_W +: ROB_W] == tag_i)) begin
                hit_o  = 1'b1;
                data_o = wb_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: operand wakeup, store commit tracking, IO-load
// gating, rollback that keeps committed stores, and a one-deep issue register.
module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int                DEPTH       = 16,
    parameter int                N_BUS       = 2,
    parameter int                FULL_MARGIN = 4,
    parameter logic [ADDR_W-1:0] IO_ADDR     = RAM_IO_ADDR,
    localparam int               IDX_W       = $clog2(DEPTH),
    localparam int               PTR_W       = IDX_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    in_valid,
    input  logic [OPNUM_W-1:0]      in_opnum,
    input  logic [DATA_W-1:0]       in_v1,
    input  logic [DATA_W-1:0]       in_v2,
    input  logic [ROB_W-1:0]        in_q1,
    input  logic [ROB_W-1:0]        in_q2,
    input  logic [DATA_W-1:0]       in_imm,
    input  logic [ROB_W-1:0]        in_rob_id,
    input  logic                    rollback,
    input  logic                    commit_valid,
    input  logic [ROB_W-1:0]        commit_rob_id,
    input  logic [ROB_W-1:0]        head_io_rob_id,
    output logic [ROB_W-1:0]        io_rob_id,
    input  logic [N_BUS-1:0]        wb_valid,
    input  logic [N_BUS*ROB_W-1:0]  wb_rob_id,
    input  logic [N_BUS*DATA_W-1:0] wb_data,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic [ROB_W-1:0]        issue_rob_id,
    output logic [OPNUM_W-1:0]      issue_opnum,
    output logic [ADDR_W-1:0]       issue_addr,
    output logic [DATA_W-1:0]       issue_data,
    output logic                    full,
    output logic [PTR_W-1:0]        count
);

    ls_entry_t          ent_q [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q, n_cstore_q;
    logic [PTR_W-1:0]   head_d, tail_d, n_cstore_d, n_cst_pop, cnt;
    logic               issue_valid_q;
    logic [ROB_W-1:0]   issue_rob_id_q;
    logic [OPNUM_W-1:0] issue_opnum_q;
    logic [ADDR_W-1:0]  issue_addr_q;
    logic [DATA_W-1:0]  issue_data_q;

    logic [IDX_W-1:0]   head_idx, tail_idx;
    ls_entry_t          head_e, new_e;
    logic [ADDR_W-1:0]  head_addr;
    logic               head_ld, head_st, head_ok, dispatch, do_insert, rb, commit_hit;
    logic [DEPTH-1:0]   commit_vec, keep, wk1_hit, wk2_hit;
    logic [DATA_W-1:0]  wk1_data [DEPTH];
    logic [DATA_W-1:0]  wk2_data [DEPTH];
    logic               byp1_hit, byp2_hit;
    logic [DATA_W-1:0]  byp1_data, byp2_data;

    assign head_idx  = head_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign head_e    = ent_q[head_idx];
    assign head_addr = head_e.v1 + head_e.imm;
    assign head_ld   = is_load(head_e.opnum);
    assign head_st   = is_store(head_e.opnum);
    assign cnt       = tail_q - head_q;
    assign rb        = rdy & rollback;

    assign head_ok = head_e.busy && (head_e.q1 == INVALID_ROB) && (head_e.q2 == INVALID_ROB) &&
                     ((head_ld && ((head_addr != IO_ADDR) || (head_io_rob_id == head_e.rob_id))) ||
                      (head_st && head_e.committed));
    // A load popped during rollback would be speculative, so only stores may leave then.
    assign dispatch  = rdy & head_ok & (~issue_valid_q | issue_ready) & ~(rb & head_ld);
    assign do_insert = rdy & in_valid & ~rollback & (cnt < PTR_W'(DEPTH));
    assign commit_hit = |commit_vec;

    assign head_d    = head_q + PTR_W'(dispatch);
    assign n_cst_pop = n_cstore_q - PTR_W'(dispatch & head_st);

    always_comb begin
        tail_d     = tail_q + PTR_W'(do_insert);
        n_cstore_d = n_cst_pop + PTR_W'(commit_hit);
        if (rb) begin
            tail_d     = head_d + n_cst_pop;
            n_cstore_d = n_cst_pop;
        end
    end

    // keep marks the committed-store run that starts at the post-pop head.
    always_comb begin
        keep       = '0;
        commit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            keep[i] = {1'b0, IDX_W'(i) - head_d[IDX_W-1:0]} < n_cst_pop;
            commit_vec[i] = rdy & commit_valid & ~rollback & ent_q[i].busy &
                            is_store(ent_q[i].opnum) & ~ent_q[i].committed &
                            (ent_q[i].rob_id == commit_rob_id);
        end
    end

    always_comb begin
        new_e        = ENTRY_RST;
        new_e.busy   = 1'b1;
        new_e.opnum  = in_opnum;
        new_e.v1     = byp1_hit ? byp1_data : in_v1;
        new_e.q1     = byp1_hit ? INVALID_ROB : in_q1;
        new_e.v2     = byp2_hit ? byp2_data : in_v2;
        new_e.q2     = byp2_hit ? INVALID_ROB : in_q2;
        new_e.imm    = in_imm;
        new_e.rob_id = in_rob_id;
    end

    ls_operand_capture #(.N_BUS(N_BUS)) u_byp1 (
        .tag_i(in_q1), .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id), .wb_data_i(wb_data),
        .hit_o(byp1_hit), .data_o(byp1_data));
    ls_operand_capture #(.N_BUS(N_BUS)) u_byp2 (
        .tag_i(in_q2), .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id), .wb_data_i(wb_data),
        .hit_o(byp2_hit), .data_o(byp2_data));

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        ls_operand_capture #(.N_BUS(N_BUS)) u_cap1 (
            .tag_i(ent_q[g].q1), .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id),
            .wb_data_i(wb_data), .hit_o(wk1_hit[g]), .data_o(wk1_data[g]));
        ls_operand_capture #(.N_BUS(N_BUS)) u_cap2 (
            .tag_i(ent_q[g].q2), .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id),
            .wb_data_i(wb_data), .hit_o(wk2_hit[g]), .data_o(wk2_data[g]));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            n_cstore_q     <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ENTRY_RST;
            issue_valid_q  <= 1'b0;
            issue_rob_id_q <= '0;
            issue_opnum_q  <= '0;
            issue_addr_q   <= NULL;
            issue_data_q   <= NULL;
        end else if (rdy) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            n_cstore_q <= n_cstore_d;
            for (int i = 0; i < DEPTH; i++) begin
                if ((rb && !keep[i]) || (dispatch && (IDX_W'(i) == head_idx))) begin
                    ent_q[i] <= ENTRY_RST;
                end else if (do_insert && (IDX_W'(i) == tail_idx)) begin
                    ent_q[i] <= new_e;
                end else if (ent_q[i].busy) begin
                    if (wk1_hit[i]) begin
                        ent_q[i].q1 <= INVALID_ROB;
                        ent_q[i].v1 <= wk1_data[i];
                    end
                    if (wk2_hit[i]) begin
                        ent_q[i].q2 <= INVALID_ROB;
                        ent_q[i].v2 <= wk2_data[i];
                    end
                    if (commit_vec[i]) ent_q[i].committed <= 1'b1;
                end
            end
            if (dispatch) begin
                issue_valid_q  <= 1'b1;
                issue_rob_id_q <= head_e.rob_id;
                issue_opnum_q  <= head_e.opnum;
                issue_addr_q   <= head_addr;
                issue_data_q   <= head_e.v2;
            end else if (issue_ready || (rb && is_load(issue_opnum_q))) begin
                issue_valid_q <= 1'b0;
            end
        end
    end

    assign issue_valid  = issue_valid_q;
    assign issue_rob_id = issue_rob_id_q;
    assign issue_opnum  = issue_opnum_q;
    assign issue_addr   = issue_addr_q;
    assign issue_data   = issue_data_q;
    assign count        = cnt;
    assign full         = cnt >= PTR_W'(DEPTH - FULL_MARGIN);
    assign io_rob_id    = (head_e.busy && head_ld && (head_addr == IO_ADDR)) ? head_e.rob_id
                                                                            : INVALID_ROB;

endmodule

// File: doc/ls_queue.md
LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DEPTH, 16: entries; power of 2, at least 4.
- N_BUS, 2: writeback wakeup buses.
- FULL_MARGIN, 4: slots kept free before full asserts.
- IO_ADDR, 32'h30000: memory-mapped IO address.
REQ-002 Ports (name, direction, width, meaning); a bare number is a width in bits:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-low reset.
- rdy, in, 1: global enable; 0 freezes the block.
- in_valid, in, 1: insert request.
- in_opnum, in, OPNUM width: operation code.
- in_v1 / in_v2, in, 32: operand values.
- in_q1 / in_q2, in, ROB id width: operand tags; INVALID_ROB means the operand is ready.
- in_imm, in, 32: offset.
- in_rob_id, in, ROB id width: owning ROB entry.
- rollback, in, 1: flush speculative entries.
- commit_valid / commit_rob_id, in, 1 / ROB id width: ROB commit notice.
- head_io_rob_id, in, ROB id width: ROB entry currently allowed to perform IO.
- io_rob_id, out, ROB id width: ROB id of a head IO load, else INVALID_ROB.
- wb_valid, in, N_BUS: per-bus writeback valid.
- wb_rob_id, in, N_BUS×ROB id width: flattened writeback tags; bus k occupies slice k.
- wb_data, in, N_BUS×32: flattened writeback data.
- issue_valid, out, 1: registered dispatch to the LS executor.
- issue_ready, in, 1: executor accepts the dispatch.
- issue_rob_id / issue_opnum / issue_addr / issue_data, out, ROB id width / OPNUM width / 32 / 32: dispatch payload.
- full, out, 1: count ≥ DEPTH−FULL_MARGIN.
- count, out, log2(DEPTH)+1: number of occupied entries.

Function
REQ-003 Circular FIFO; head and tail pointers carry an extra wrap bit; count = tail−head; empty when count=0, full capacity when count=DEPTH.
REQ-004 Classes: load = opnum ≤ OPNUM_LHU; store = opnum ≥ OPNUM_SB; addr = v1+imm, truncated mod 2^32.
REQ-005 Insert at tail when rdy & in_valid & ~rollback & count<DEPTH; in_valid at count=DEPTH is dropped.
REQ-006 Insert bypass: an in_q matching a valid wb_rob_id in the same cycle stores INVALID_ROB and that bus's data; the lowest bus index wins.
REQ-007 Wakeup: every busy entry whose q1/q2 matches a valid wb bus captures the data and clears the tag; the lowest bus index wins.
REQ-008 Commit: a busy, uncommitted store whose rob_id equals commit_rob_id sets committed and increments n_cstore; commits aimed at loads or absent ids are ignored.
REQ-009 Head eligibility requires busy and q1=q2=INVALID_ROB, plus:
- load: addr≠IO_ADDR, or head_io_rob_id=rob_id;
- store: committed.
REQ-010 Dispatch when the head is eligible and (~issue_valid | issue_ready):
- pop the head;
- load the issue registers: issue_data=v2, which is don't-care for loads;
- issue_valid=1 on the next cycle.
A committed store dispatch decrements n_cstore.
REQ-011 Issue handshake:
- Payload is held stable while issue_valid & ~issue_ready.
- If issue_ready and no new dispatch occurs, issue_valid clears.
- Back-to-back dispatch is allowed at one per cycle.
REQ-012 Latency: the head becomes eligible at edge N; issue_valid is visible after edge N+1 when the issue slot is free.
REQ-013 io_rob_id is combinational: rob_id[head] if the head is a busy load with addr=IO_ADDR, else INVALID_ROB.
REQ-014 Rollback (sampled only when rdy):
- Committed stores are contiguous from head and all survive.
- tail←head'+n_cstore', where the primes denote values after any same-cycle pop.
- All other entries are cleared.
- Insert and commit are ignored that cycle.
- A held issue register holding a load is dropped (issue_valid←0); one holding a store is kept.
REQ-015 Rollback with n_cstore=0 empties the queue and leaves head unchanged.
REQ-016 rdy=0: all state is frozen; inputs other than rst are ignored; outputs hold their values.
REQ-017 Simultaneous insert and pop at any count<DEPTH: both are performed and count is unchanged.
REQ-018 Wrap-around: pointers wrap modulo DEPTH with the wrap bit toggling; the full/empty distinction holds at tail=head.

Reset
REQ-019 rst=0 at a clock edge overrides rdy and rollback, and sets:
- head=tail=0, count=0, n_cstore=0;
- all busy/committed flags=0, all tags=INVALID_ROB;
- issue_valid=0, issue payload=0.
REQ-020 Reset values of the outputs: full=0; io_rob_id=INVALID_ROB; count=0.

Structure
REQ-021 The shared defines package holds OPNUM_*, INVALID_ROB, RAM_IO_ADDR, the data/address/ROB-id widths, and NULL.
REQ-022 One sub-module, ls_operand_capture: an N_BUS tag match and priority mux returning (hit, data). It is instantiated for both insert bypass and per-entry wakeup.

Verification
REQ-023 Insert LW with q1=INVALID_ROB, v1=0x100, imm=4 -> issue_valid two cycles later with issue_addr=0x104.
REQ-024 Insert SW with q2=5, then wb bus1 rob5 data=0xAB, then commit its rob_id -> dispatch with issue_data=0xAB only after the commit.
REQ-025 IO load to 0x30000 at head with head_io_rob_id≠rob_id -> io_rob_id=rob_id, no dispatch; when they become equal -> dispatch.
REQ-026 Queue holds 2 committed stores and 3 loads; rollback -> count=2, the stores dispatch in order, the loads never issue.
REQ-027 Hold issue_ready=0 for 3 cycles with the head eligible -> payload stable and no pop; fill DEPTH inserts -> full at DEPTH−4 and the 17th insert is dropped.
REQ-028 Assert rst=0 mid-dispatch with rollback=1 -> next cycle count=0, issue_valid=0.
